// File: rtl/dpram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dpram_arbiter_if
//   Requester-side bundle of the dpram_arbiter. The requesters share this
//   bundle. Each requester i owns bit i of the per-requester vectors and owns
//   slice [i*WIDTH +: WIDTH] of the packed address and write-data buses.
//
//   Requester -> arbiter : req, lock, we, addr, wdata
//   Arbiter -> requester : ack (one-hot accept), rvalid (one-hot read strobe),
//                          rdata (shared read data)
//
//   Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dpram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 3
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output ack, rvalid, rdata
  );
endinterface : dpram_arbiter_if

// File: rtl/dpram_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_arbiter
//   Round-robin arbiter that shares one port of a dpram between NUM_REQ
//   requesters. An access is accepted in the cycle it wins. Read data returns
//   exactly one cycle later. A locked requester may hold the port for up to
//   MAX_BURST consecutive grants while another requester is waiting.
//
//   Ports
//     clk           : clock, rising edge
//     rst           : asynchronous, active-high reset
//     req_if        : requester bundle (slave modport)
//     ram_address_o : address to the dpram
//     ram_data_o    : write data to the dpram
//     ram_wren_o    : write enable to the dpram
//     ram_cs_o      : chip select; high only in cycles that have a grant
//     ram_q_i       : read data from the dpram, passed straight to rdata
// -----------------------------------------------------------------------------
module dpram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 3,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dpram_arbiter_if.slave        req_if,
  output logic [ADDR_WIDTH-1:0] ram_address_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_wren_o,
  output logic                  ram_cs_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]            state_q,     state_d;
  logic [IW-1:0]         owner_q,     owner_d;
  logic [CW-1:0]         cnt_q,       cnt_d;
  logic [IW-1:0]         ptr_q,       ptr_d;
  logic                  tag_valid_q, tag_valid_d;
  logic [IW-1:0]         tag_idx_q,   tag_idx_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;

  logic          grant_valid;
  logic          grant_ok;
  logic [IW-1:0] grant_idx;
  logic          others_pending;
  logic          hold;
  int            idx;

  // Grant selection: a locked owner that is still within budget wins first.
  // Otherwise the winner is the first requester with req high, searching from
  // the priority pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    grant_valid    = 1'b0;
    grant_idx      = '0;
    idx            = 0;
    others_pending = |(req_if.req & ~(NUM_REQ'(1) << owner_q));
    hold           = (state_q == ST_OWNED) && req_if.req[owner_q] && req_if.lock[owner_q] &&
                     ((cnt_q < CW'(MAX_BURST)) || !others_pending);

    if (hold) begin
      grant_valid = 1'b1;
      grant_idx   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!grant_valid && req_if.req[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = IW'(idx);
        end
      end
    end
  end

  // Reset suppresses the combinational accept path, so ack, ram_cs and
  // ram_wren stay low for the whole reset period.
  assign grant_ok = grant_valid && !rst;

  always_comb begin
    req_if.ack    = grant_ok ? (NUM_REQ'(1) << grant_idx) : '0;
    ram_cs_o      = grant_ok;
    ram_wren_o    = grant_ok && req_if.we[grant_idx];
    ram_address_o = grant_ok ? req_if.addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH] : last_addr_q;
    ram_data_o    = grant_ok ? req_if.wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : last_data_q;
    req_if.rvalid = tag_valid_q ? (NUM_REQ'(1) << tag_idx_q) : '0;
    req_if.rdata  = ram_q_i;
  end

  // Next-state logic: ownership and burst count, the rotating pointer, and
  // the read-return tag.
  always_comb begin
    state_d     = ST_IDLE;
    owner_d     = owner_q;
    cnt_d       = '0;
    ptr_d       = ptr_q;
    tag_valid_d = grant_valid && !req_if.we[grant_idx];
    tag_idx_d   = grant_idx;
    last_addr_d = ram_address_o;
    last_data_d = ram_data_o;

    if (grant_valid) begin
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IW'(1);
      if (req_if.lock[grant_idx]) begin
        state_d = ST_OWNED;
        owner_d = grant_idx;
        // The count continues only when the same owner is granted again.
        // It saturates, so a forced rotation stays armed while others wait.
        if ((state_q == ST_OWNED) && (owner_q == grant_idx))
          cnt_d = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + CW'(1);
        else
          cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_idx_q   <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_idx_q   <= tag_idx_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

endmodule : dpram_arbiter

// File: tb/tb_dpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_arbiter
//   Directed bench for dpram_arbiter with NUM_REQ=3, MAX_BURST=4. A small
//   behavioural dpram port (registered address, new-data read-during-write)
//   is attached to the RAM side.
// -----------------------------------------------------------------------------
module tb_dpram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 3;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          ram_cs;
  logic [DW-1:0] ram_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dpram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  dpram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_if        (bus),
    .ram_address_o (ram_address),
    .ram_data_o    (ram_data),
    .ram_wren_o    (ram_wren),
    .ram_cs_o      (ram_cs),
    .ram_q_i       (ram_q)
  );

  // Behavioural RAM port: write on the edge, registered read address.
  logic [DW-1:0] mem [256];
  logic [AW-1:0] ram_addr_q = '0;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_addr_q <= ram_address;
    end
  end
  assign ram_q = mem[ram_addr_q];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[i]            = w;
    bus.addr[i*AW +: AW] = a;
    bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Runs a fixed req/lock pattern and compares the grant sequence.
  task automatic run_grants(input string tag, input logic [NR-1:0] r, input logic [NR-1:0] l,
                            input logic [NR-1:0] exp_q[$]);
    bus.req  = r;
    bus.lock = l;
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s ack[%0d]", tag, i), 32'(bus.ack), 32'(exp_q[i]));
      step();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] seq[$];

    rst = 1'b1;
    clear_inputs();

    // Reset values.
    @(negedge clk);
    check("rst ack",    32'(bus.ack),     32'h0);
    check("rst rvalid", 32'(bus.rvalid),  32'h0);
    check("rst cs",     32'(ram_cs),      32'h0);
    check("rst wren",   32'(ram_wren),    32'h0);
    check("rst addr",   32'(ram_address), 32'h0);
    check("rst data",   32'(ram_data),    32'h0);
    step();
    rst = 1'b0;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle ack", 32'(bus.ack), 32'h0);
      check("idle cs",  32'(ram_cs),  32'h0);
      step();
    end

    // Preload 0x5A at 0x12 through requester 0.
    bus.req = 3'b001;
    set_port(0, 1'b1, 8'h12, 8'h5A);
    @(negedge clk);
    check("pre ack",  32'(bus.ack),  32'h1);
    check("pre wren", 32'(ram_wren), 32'h1);
    check("pre data", 32'(ram_data), 32'h5A);
    step();

    // Single read of 0x12 by requester 0.
    set_port(0, 1'b0, 8'h12, 8'h00);
    @(negedge clk);
    check("rd ack",    32'(bus.ack),     32'h1);
    check("rd cs",     32'(ram_cs),      32'h1);
    check("rd wren",   32'(ram_wren),    32'h0);
    check("rd addr",   32'(ram_address), 32'h12);
    check("rd rvalid", 32'(bus.rvalid),  32'h0);
    step();
    clear_inputs();
    @(negedge clk);
    check("rd+1 ack",    32'(bus.ack),     32'h0);
    check("rd+1 cs",     32'(ram_cs),      32'h0);
    check("rd+1 rvalid", 32'(bus.rvalid),  32'h1);
    check("rd+1 rdata",  32'(bus.rdata),   32'h5A);
    check("rd+1 hold",   32'(ram_address), 32'h12);
    step();
    @(negedge clk);
    check("rd+2 rvalid", 32'(bus.rvalid), 32'h0);

    // Contention without lock: strict rotation 0,1,2,0,1,2.
    do_reset();
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    run_grants("rr", 3'b111, 3'b000, seq);

    // Locked burst against a competitor: four grants, forced rotation, back.
    do_reset();
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
    run_grants("burst", 3'b011, 3'b001, seq);

    // Locked burst alone: never rotated away.
    do_reset();
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    run_grants("solo", 3'b001, 3'b001, seq);

    // All locked: each owner holds MAX_BURST grants, then rotation.
    do_reset();
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010,
            3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    run_grants("all", 3'b111, 3'b111, seq);

    // Write by requester 1, then read of the same address by requester 2.
    do_reset();
    bus.req = 3'b010;
    set_port(1, 1'b1, 8'h03, 8'hA7);
    @(negedge clk);
    check("wr ack",  32'(bus.ack),     32'h2);
    check("wr wren", 32'(ram_wren),    32'h1);
    check("wr cs",   32'(ram_cs),      32'h1);
    check("wr addr", 32'(ram_address), 32'h03);
    check("wr data", 32'(ram_data),    32'hA7);
    step();
    bus.req = 3'b100;
    set_port(1, 1'b0, 8'h00, 8'h00);
    set_port(2, 1'b0, 8'h03, 8'h00);
    @(negedge clk);
    check("wr+1 ack",    32'(bus.ack),    32'h4);
    check("wr+1 rvalid", 32'(bus.rvalid), 32'h0);
    check("wr+1 wren",   32'(ram_wren),   32'h0);
    step();
    clear_inputs();
    @(negedge clk);
    check("wr+2 rvalid", 32'(bus.rvalid),  32'h4);
    check("wr+2 rdata",  32'(bus.rdata),   32'hA7);
    check("wr+2 cs",     32'(ram_cs),      32'h0);
    check("wr+2 hold",   32'(ram_address), 32'h03);
    step();

    // Reset while a read is in flight.
    do_reset();
    bus.req = 3'b001;
    set_port(0, 1'b0, 8'h12, 8'h00);
    @(negedge clk);
    check("mid ack", 32'(bus.ack), 32'h1);
    step();
    rst     = 1'b1;
    bus.req = 3'b101;
    @(negedge clk);
    check("mid rvalid", 32'(bus.rvalid), 32'h0);
    check("mid ack0",   32'(bus.ack),    32'h0);
    check("mid cs",     32'(ram_cs),     32'h0);
    check("mid wren",   32'(ram_wren),   32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post ack",    32'(bus.ack),    32'h1);
    check("post rvalid", 32'(bus.rvalid), 32'h0);
    step();
    clear_inputs();
    @(negedge clk);
    check("post+1 rvalid", 32'(bus.rvalid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dpram_arbiter

// File: doc/dpram_arbiter.md
# dpram_arbiter

Round-robin arbiter that shares one port of a `dpram` instance between up to four requesters, such as the CPU bus, the DMA engine and the debug/host loader. It has one-cycle accept, a fixed one-cycle read return and optional locked bursts. It drives the RAM port's address, data, write-enable and chip-select, and routes the returned read data back to the requester that issued the read. It sits between the requesters and the RAM, and the RAM's other port stays unaffected.

## Interface
- addr_width, 8, RAM address width; must match the attached `dpram`
- data_width, 8, RAM data width; must match the attached `dpram`
- num_req, 3, number of requesters; legal range 2..4
- max_burst, 4, maximum consecutive grants one locked requester may hold while another requester is pending; legal range 1..16

- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  num_req  per-requester access request, level
- lock  in  num_req  per-requester burst hold; only honoured while the same requester's req is high
- we  in  num_req  per-requester write flag: 1 = write, 0 = read
- addr  in  num_req*addr_width  packed addresses; requester i uses slice [i*addr_width +: addr_width]
- wdata  in  num_req*data_width  packed write data, sliced the same way
- ack  out  num_req  one-hot (or zero) accept; the access is performed this cycle
- rvalid  out  num_req  one-hot (or zero) read-data strobe
- rdata  out  data_width  read data, meaningful only while some rvalid bit is high
- ram_address  out  addr_width  to dpram address
- ram_data  out  data_width  to dpram data
- ram_wren  out  1  to dpram wren
- ram_cs  out  1  to dpram cs; high only on cycles when an access is granted
- ram_q  in  data_width  from dpram q (unregistered output)

## Operation
- The arbiter is two-state: IDLE (no owner) and OWNED (owner index o, burst count c).
- Priority pointer p is registered and reset to 0.
  - Normal grant: the first requester with req high, searching p, p+1, … mod num_req.
- Grant is combinational within the cycle:
  - ack[g] = 1.
  - ram_address, ram_data and ram_wren come from requester g's slices and we[g].
  - ram_cs = 1.
  - With no grant, ram_cs = 0, ram_wren = 0, and ram_address/ram_data hold the last granted values.
- Burst hold: in OWNED, if req[o] and lock[o] are both high, o is granted again ahead of the pointer search, provided one of these holds:
  - c < max_burst, or
  - no other requester has req high.
- After every grant to g:
  - If lock[g] is high, the next state is OWNED(g, c+1); c restarts at 1 when g differs from the previous owner.
  - If lock[g] is low, the next state is IDLE with c = 0.
  - In both cases p ← (g+1) mod num_req.
- Forced rotation: when c = max_burst and another requester is pending, the normal search from p runs and the locked requester loses the grant. c saturates at max_burst.
- Dropping req[o] in OWNED: the state returns to IDLE that cycle and the normal search applies.
- Read return: a registered tag records the granted index and read flag. In the next cycle rvalid[tag] = 1 and rdata = ram_q.
  - Writes produce no rvalid.
  - ram_q is passed straight through to rdata, with no registering.
- The RAM is configured for new-data read-during-write, so a read granted the cycle after a write to the same address returns the new data. No forwarding logic is needed.
- Reset mid-operation:
  - All state clears immediately: IDLE, p = 0, c = 0, tag invalid.
  - ack, rvalid, ram_cs and ram_wren go to 0 while reset is high.
  - An access in flight is dropped; no rvalid is produced for it.

## Timing
- Accept latency is 0 cycles: a request with req high is acked in the same cycle when it wins. The requester may change addr/wdata or drop req in the next cycle.
- Read latency is 1 cycle: for an ack in cycle N, rvalid and rdata appear in cycle N+1.
- Back-to-back accesses give throughput of one access per cycle across all requesters.
- Reset values:
  - ack = 0, rvalid = 0, rdata = ram_q (don't-care).
  - ram_cs = 0, ram_wren = 0, ram_address = 0, ram_data = 0.
- Simultaneous events:
  - A new grant and an rvalid for the previous read can occur in the same cycle.
  - The same requester can receive rvalid and ack in one cycle.
- Fairness bound: with all requesters continuously pending and locked, any requester waits at most (num_req-1)*max_burst cycles.

## Test plan
- Reset then idle, num_req=3: all req=0 → ack=000, ram_cs=0 for 10 cycles.
- Single read: req0 reads addr 0x12 (RAM holds 0x5A) → ack=001 in cycle N, rvalid=001 with rdata=0x5A in N+1, ram_cs=1 only in N.
- Contention, no lock: req=111 held for 6 cycles from reset → grant order 0,1,2,0,1,2; each ack is one-hot.
- Locked burst, max_burst=4: req0 and lock0 held, req1 also high → requester 0 granted 4 consecutive cycles, then requester 1, then requester 0 again. Locked burst alone: req0 and lock0 held, others idle for 8 cycles → requester 0 granted all 8 cycles.
- Write then read: requester 1 writes 0xA7 to 0x03 in cycle N, requester 2 reads 0x03 in N+1 → rvalid=100 with rdata=0xA7 in N+2, and no rvalid in N+1.
- Reset mid-read: read acked in cycle N, reset asserted during N+1 → rvalid stays 0 and p = 0 after release; the first grant after release goes to the lowest-indexed pending requester.
